// File: rtl/nearest_decimation_if.sv
// rtl/nearest_decimation_if.sv - vsync/href/gray pixel stream bundle
interface nearest_decimation_if;
  logic       vsync;
  logic       href;
  logic [7:0] gray;

  modport master (output vsync, output href, output gray);
  modport slave  (input  vsync, input  href, input  gray);
endinterface

// File: rtl/nearest_decimation.sv
// rtl/nearest_decimation.sv - nearest-neighbour frame downscaler for the gray stream
module nearest_decimation #(
  parameter logic [10:0] C_SRC_IMG_WIDTH  = 11'd1920,
  parameter logic [10:0] C_SRC_IMG_HEIGHT = 11'd1080,
  parameter logic [10:0] C_DST_IMG_WIDTH  = 11'd640,
  parameter logic [10:0] C_DST_IMG_HEIGHT = 11'd480,
  parameter logic [23:0] C_X_RATIO        = 24'h030000,
  parameter logic [23:0] C_Y_RATIO        = 24'h024000
) (
  input  logic                        clk_in1,
  input  logic                        rst,
  nearest_decimation_if.slave         per_img,
  nearest_decimation_if.master        post_img,
  output logic                        frame_short
);

  typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_DONE} state_t;

  state_t      r_state;
  logic        r_vsync_dly;
  logic        r_href_dly;
  logic        r_armed;
  logic [10:0] r_hs_cnt;
  logic [10:0] r_vs_cnt;
  logic [10:0] r_dst_x_cnt;
  logic [10:0] r_dst_y_cnt;
  logic [26:0] r_x_acc;
  logic [26:0] r_y_acc;

  logic        w_vs_rise;
  logic        w_href_neg;
  logic [10:0] w_x_tgt;
  logic [10:0] w_y_tgt;
  logic        w_row_hit;
  logic        w_keep;

  // A rise only counts once vsync has been seen low since reset, so a frame
  // already in progress when reset drops is ignored until the next one starts.
  assign w_vs_rise  = per_img.vsync & ~r_vsync_dly & r_armed;
  assign w_href_neg = r_href_dly & ~per_img.href;

  // Round-to-nearest destination grid point in source coordinates.
  assign w_x_tgt = r_x_acc[26:16] + {10'd0, r_x_acc[15]};
  assign w_y_tgt = r_y_acc[26:16] + {10'd0, r_y_acc[15]};

  // Source-window guards keep a mismatched ratio from emitting beyond the frame.
  assign w_row_hit = (r_vs_cnt == w_y_tgt) & (r_dst_y_cnt < C_DST_IMG_HEIGHT)
                   & (r_vs_cnt < C_SRC_IMG_HEIGHT);

  assign w_keep = (r_state == S_ACTIVE) & per_img.vsync & per_img.href & w_row_hit
                & (r_hs_cnt == w_x_tgt) & (r_dst_x_cnt < C_DST_IMG_WIDTH)
                & (r_hs_cnt < C_SRC_IMG_WIDTH);

  assign post_img.vsync = r_vsync_dly;

  // Frame FSM, source/destination counters, accumulators and registered outputs.
  always_ff @(posedge clk_in1) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_vsync_dly   <= 1'b0;
      r_href_dly    <= 1'b0;
      r_armed       <= ~per_img.vsync;
      r_hs_cnt      <= 11'd0;
      r_vs_cnt      <= 11'd0;
      r_dst_x_cnt   <= 11'd0;
      r_dst_y_cnt   <= 11'd0;
      r_x_acc       <= 27'd0;
      r_y_acc       <= 27'd0;
      post_img.href <= 1'b0;
      post_img.gray <= 8'd0;
      frame_short   <= 1'b0;
    end else begin
      r_vsync_dly   <= per_img.vsync;
      r_href_dly    <= per_img.href;
      r_armed       <= r_armed | ~per_img.vsync;
      post_img.href <= w_keep;
      if (w_keep) begin
        post_img.gray <= per_img.gray;
      end
      frame_short <= (r_state == S_ACTIVE) & r_vsync_dly & ~per_img.vsync
                   & (r_dst_y_cnt < C_DST_IMG_HEIGHT);

      case (r_state)
        S_IDLE: begin
          r_hs_cnt    <= 11'd0;
          r_vs_cnt    <= 11'd0;
          r_dst_x_cnt <= 11'd0;
          r_dst_y_cnt <= 11'd0;
          r_x_acc     <= 27'd0;
          r_y_acc     <= 27'd0;
          if (w_vs_rise) begin
            r_state <= S_ACTIVE;
          end
        end
        S_ACTIVE, S_DONE: begin
          if (!per_img.href) begin
            r_hs_cnt <= 11'd0;
          end else if (per_img.vsync) begin
            r_hs_cnt <= r_hs_cnt + 11'd1;
          end
          if (w_keep) begin
            r_x_acc     <= r_x_acc + {3'd0, C_X_RATIO};
            r_dst_x_cnt <= r_dst_x_cnt + 11'd1;
          end
          if (w_href_neg && (r_state == S_ACTIVE)) begin
            r_vs_cnt    <= r_vs_cnt + 11'd1;
            r_x_acc     <= 27'd0;
            r_dst_x_cnt <= 11'd0;
            if (w_row_hit) begin
              r_y_acc     <= r_y_acc + {3'd0, C_Y_RATIO};
              r_dst_y_cnt <= r_dst_y_cnt + 11'd1;
            end
          end
          if (!per_img.vsync) begin
            r_state <= S_IDLE;
          end else if ((r_state == S_ACTIVE) && (r_dst_y_cnt == C_DST_IMG_HEIGHT)) begin
            r_state <= S_DONE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nearest_decimation.sv
// tb/tb_nearest_decimation.sv - randomized bench for nearest_decimation against a grid model
module tb_nearest_decimation;

  localparam int A_SW = 60;
  localparam int A_SH = 27;
  localparam int A_DW = 20;
  localparam int A_DH = 12;
  localparam int A_XR = 32'h030000;
  localparam int A_YR = 32'h024000;
  localparam int B_W  = 64;
  localparam int B_H  = 8;

  logic clk;
  logic rst_a;
  logic rst_b;
  logic fs_a;
  logic fs_b;

  int checks;
  int errors;
  int a_strobes;
  int a_fs_pulses;
  int b_strobes;
  int exp_n;

  nearest_decimation_if in_a ();
  nearest_decimation_if out_a ();
  nearest_decimation_if in_b ();
  nearest_decimation_if out_b ();

  nearest_decimation #(
    .C_SRC_IMG_WIDTH (11'd60),
    .C_SRC_IMG_HEIGHT(11'd27),
    .C_DST_IMG_WIDTH (11'd20),
    .C_DST_IMG_HEIGHT(11'd12),
    .C_X_RATIO       (24'h030000),
    .C_Y_RATIO       (24'h024000)
  ) u_dut_a (
    .clk_in1    (clk),
    .rst        (rst_a),
    .per_img    (in_a),
    .post_img   (out_a),
    .frame_short(fs_a)
  );

  nearest_decimation #(
    .C_SRC_IMG_WIDTH (11'd64),
    .C_SRC_IMG_HEIGHT(11'd8),
    .C_DST_IMG_WIDTH (11'd64),
    .C_DST_IMG_HEIGHT(11'd8),
    .C_X_RATIO       (24'h010000),
    .C_Y_RATIO       (24'h010000)
  ) u_dut_b (
    .clk_in1    (clk),
    .rst        (rst_b),
    .per_img    (in_b),
    .post_img   (out_b),
    .frame_short(fs_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Source coordinate of destination index k: k*ratio rounded to nearest.
  function automatic int tgt(input int k, input int ratio);
    return (k * ratio + 32'h8000) >>> 16;
  endfunction

  function automatic bit col_kept(input int c);
    for (int k = 0; k < A_DW; k++) begin
      if (tgt(k, A_XR) == c) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc_a(input logic vs, input logic hr, input logic [7:0] g,
                       input logic r, input logic keep, input logic fs_exp);
    in_a.vsync = vs;
    in_a.href  = hr;
    in_a.gray  = g;
    rst_a      = r;
    @(posedge clk);
    #1;
    chk("a_vsync", {31'd0, out_a.vsync}, {31'd0, r ? 1'b0 : vs});
    chk("a_href", {31'd0, out_a.href}, {31'd0, r ? 1'b0 : keep});
    if (r) chk("a_gray_rst", {24'd0, out_a.gray}, 32'd0);
    else if (keep) chk("a_gray", {24'd0, out_a.gray}, {24'd0, g});
    chk("a_frame_short", {31'd0, fs_a}, {31'd0, r ? 1'b0 : fs_exp});
    if (out_a.href === 1'b1) a_strobes++;
    if (fs_a === 1'b1) a_fs_pulses++;
  endtask

  // One frame into DUT A; the model walks the destination grid line by line.
  task automatic frame_a(input int nl, input int ll, input int sl_idx, input int sl_len,
                         input int rst_line, output int exp_strobes);
    int  dy;
    bit  dead;
    dy = 0;
    dead = 1'b0;
    exp_strobes = 0;
    a_strobes = 0;
    a_fs_pulses = 0;
    for (int i = 0; i < 3; i++) cyc_a(1'b1, 1'b0, 8'($urandom), 1'b0, 1'b0, 1'b0);
    for (int r = 0; r < nl; r++) begin
      int len;
      bit rowk;
      len  = (r == sl_idx) ? sl_len : ll;
      rowk = !dead && (dy < A_DH) && (r == tgt(dy, A_YR));
      for (int c = 0; c < len; c++) begin
        logic [7:0] g;
        bit rp;
        bit k;
        g  = 8'($urandom);
        rp = (r == rst_line) && (c == len / 2);
        if (rp) dead = 1'b1;
        k  = rowk && !dead && col_kept(c);
        if (k) exp_strobes++;
        cyc_a(1'b1, 1'b1, g, rp, k, 1'b0);
      end
      if (rowk && !dead) dy++;
      for (int i = 0; i < int'($urandom_range(3, 7)); i++)
        cyc_a(1'b1, 1'b0, 8'($urandom), 1'b0, 1'b0, 1'b0);
    end
    cyc_a(1'b0, 1'b0, 8'($urandom), 1'b0, 1'b0, !dead && (dy < A_DH));
    for (int i = 0; i < 3; i++) cyc_a(1'b0, 1'b0, 8'($urandom), 1'b0, 1'b0, 1'b0);
    chk("a_frame_strobes", a_strobes, exp_strobes);
  endtask

  // Ratio 1.0: output is the input delayed one cycle.
  task automatic cyc_b(input logic vs, input logic hr, input logic [7:0] g);
    in_b.vsync = vs;
    in_b.href  = hr;
    in_b.gray  = g;
    @(posedge clk);
    #1;
    chk("b_vsync", {31'd0, out_b.vsync}, {31'd0, vs});
    chk("b_href", {31'd0, out_b.href}, {31'd0, hr});
    if (hr) chk("b_gray", {24'd0, out_b.gray}, {24'd0, g});
    chk("b_frame_short", {31'd0, fs_b}, 32'd0);
    if (out_b.href === 1'b1) b_strobes++;
  endtask

  task automatic frame_b();
    b_strobes = 0;
    for (int i = 0; i < 2; i++) cyc_b(1'b1, 1'b0, 8'($urandom));
    for (int r = 0; r < B_H; r++) begin
      for (int c = 0; c < B_W; c++) cyc_b(1'b1, 1'b1, 8'($urandom));
      for (int i = 0; i < int'($urandom_range(1, 4)); i++) cyc_b(1'b1, 1'b0, 8'($urandom));
    end
    for (int i = 0; i < 3; i++) cyc_b(1'b0, 1'b0, 8'($urandom));
    chk("b_frame_strobes", b_strobes, B_W * B_H);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    a_strobes = 0;
    a_fs_pulses = 0;
    b_strobes = 0;
    rst_b = 1'b1;
    in_b.vsync = 1'b0;
    in_b.href  = 1'b0;
    in_b.gray  = 8'd0;

    // Reset with vsync already high, then a partial frame that must be ignored.
    cyc_a(1'b1, 1'b0, 8'h5a, 1'b1, 1'b0, 1'b0);
    cyc_a(1'b1, 1'b0, 8'h5a, 1'b1, 1'b0, 1'b0);
    chk("b_reset_href", {31'd0, out_b.href}, 32'd0);
    chk("b_reset_vsync", {31'd0, out_b.vsync}, 32'd0);
    chk("b_reset_gray", {24'd0, out_b.gray}, 32'd0);
    for (int r = 0; r < 2; r++) begin
      for (int c = 0; c < A_SW; c++) cyc_a(1'b1, 1'b1, 8'($urandom), 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) cyc_a(1'b1, 1'b0, 8'($urandom), 1'b0, 1'b0, 1'b0);
    end
    for (int i = 0; i < 3; i++) cyc_a(1'b0, 1'b0, 8'($urandom), 1'b0, 1'b0, 1'b0);

    // Full frame.
    frame_a(A_SH, A_SW, -1, 0, -1, exp_n);
    chk("a_full_count", exp_n, A_DW * A_DH);
    chk("a_full_no_short", a_fs_pulses, 0);

    // Frame ends after 10 lines.
    frame_a(10, A_SW, -1, 0, -1, exp_n);
    chk("a_short_pulses", a_fs_pulses, 1);

    // Recovery frame.
    frame_a(A_SH, A_SW, -1, 0, -1, exp_n);
    chk("a_recover_count", exp_n, A_DW * A_DH);

    // One short source line on a kept row.
    frame_a(A_SH, A_SW, 5, 40, -1, exp_n);
    chk("a_shortline_no_short", a_fs_pulses, 0);

    // Reset mid-frame, then a complete frame.
    frame_a(A_SH, A_SW, -1, 0, 10, exp_n);
    chk("a_rst_no_short", a_fs_pulses, 0);
    frame_a(A_SH, A_SW, -1, 0, -1, exp_n);
    chk("a_after_rst_count", exp_n, A_DW * A_DH);

    // Over-long lines and extra lines.
    frame_a(30, 66, -1, 0, -1, exp_n);
    chk("a_long_count", exp_n, A_DW * A_DH);
    chk("a_long_no_short", a_fs_pulses, 0);

    in_a.vsync = 1'b0;
    in_a.href  = 1'b0;
    in_a.gray  = 8'd0;

    // Ratio 1.0 pass-through.
    @(posedge clk);
    #1;
    rst_b = 1'b0;
    for (int i = 0; i < 3; i++) cyc_b(1'b0, 1'b0, 8'($urandom));
    frame_b();
    frame_b();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/nearest_decimation.md
# nearest_decimation

Single-clock nearest-neighbour downscaler for the ISP gray-stream path. It decimates an incoming vsync/href/gray frame from C_SRC_IMG_WIDTH×C_SRC_IMG_HEIGHT to C_DST_IMG_WIDTH×C_DST_IMG_HEIGHT by forwarding only the source pixels nearest to each destination grid point and dropping all others. It is the reducing counterpart of the nearest-neighbour upscaler. Because it never needs to re-read a pixel, it needs no line buffer and no FIFO.

## Interface
Parameters:
- C_SRC_IMG_WIDTH, 11'd1920, source pixels per line
- C_SRC_IMG_HEIGHT, 11'd1080, source lines per frame
- C_DST_IMG_WIDTH, 11'd640, destination pixels per line
- C_DST_IMG_HEIGHT, 11'd480, destination lines per frame
- C_X_RATIO, 24'h030000, floor(SRC_W/DST_W·2^16), unsigned 8.16 fixed-point, must be ≥ 24'h010000
- C_Y_RATIO, 24'h024000, floor(SRC_H/DST_H·2^16), unsigned 8.16 fixed-point, must be ≥ 24'h010000

Ports:
- clk_in1  in  1  pixel clock; one clock only; reset is synchronous and active-high
- rst  in  1  synchronous active-high reset
- per_img_vsync  in  1  input frame valid, high for the whole frame
- per_img_href  in  1  input line/pixel valid
- per_img_gray  in  8  input pixel
- post_img_vsync  out  1  per_img_vsync delayed 1 cycle
- post_img_href  out  1  kept-pixel strobe
- post_img_gray  out  8  kept pixel
- frame_short  out  1  1-cycle pulse: frame ended before all destination lines were produced

## Operation
- Edge detect: vsync_dly and href_dly are registered copies of the inputs. vs_rise = vsync & ~vsync_dly. href_neg = href_dly & ~href.
- FSM states:
  - S_IDLE: all counters and accumulators are cleared. On vs_rise, go to S_ACTIVE.
  - S_ACTIVE: when vsync is low, go to S_IDLE. When dst_y_cnt reaches C_DST_IMG_HEIGHT, go to S_DONE.
  - S_DONE: drop every pixel. When vsync is low, go to S_IDLE.
- Counters, all 11 bits:
  - hs_cnt: source column. Increments on each vsync&href cycle and clears when href is low.
  - vs_cnt: source line. Increments on href_neg.
  - dst_x_cnt, dst_y_cnt: destination column and line.
- Accumulators x_acc and y_acc are 27 bits in 11.16 format.
  - Targets round to nearest: x_tgt = x_acc[26:16] + x_acc[15], and y_tgt is formed the same way from y_acc.
- Line keep: row_hit = (vs_cnt == y_tgt) & (dst_y_cnt < C_DST_IMG_HEIGHT).
- Pixel keep: S_ACTIVE & vsync & href & row_hit & (hs_cnt == x_tgt) & (dst_x_cnt < C_DST_IMG_WIDTH).
  - On keep: x_acc += C_X_RATIO and dst_x_cnt++.
  - Ratio ≥ 1.0 guarantees each new target is > the current hs_cnt, so no target is skipped.
- On href_neg in S_ACTIVE:
  - vs_cnt++.
  - x_acc and dst_x_cnt clear.
  - If row_hit, then y_acc += C_Y_RATIO and dst_y_cnt++.
- Boundary conditions:
  - Source line longer than SRC_W: the extra pixels are dropped by the dst_x_cnt cap.
  - Source line shorter: that destination line is emitted short; dst_y_cnt still advances.
  - Extra source lines: dropped in S_DONE.
  - vsync high out of reset: stays in S_IDLE until a fresh vs_rise, so the partial frame is ignored.
- frame_short pulses when state is S_ACTIVE, vsync_dly=1, vsync=0, and dst_y_cnt < C_DST_IMG_HEIGHT.
- Arithmetic widths: the accumulators do not wrap within a legal frame (max ≈ 1920.0 < 2^11). The 24-bit ratio is zero-extended to 27 bits before addition.

## Timing
- Every output is registered, so latency from input to output is 1 cycle.
  - post_img_vsync = vsync_dly.
  - post_img_href and post_img_gray in cycle n+1 correspond to the input in cycle n.
- post_img_gray is loaded only on keep and otherwise holds its value.
- Reset values: post_img_vsync=0, post_img_href=0, post_img_gray=0, frame_short=0, state=S_IDLE, all counters and accumulators 0.
- Reset asserted mid-frame: the outputs are 0 on the next edge, and output resumes only after the next vs_rise.
- No backpressure: the block accepts one pixel per cycle whenever href is high.
- Kept pixels on one line keep their source spacing; they are not packed together.
- Output href may toggle every cycle when the ratio is 1.0.

## Test plan
- Default parameters, full 1920×1080 frame with gray = column[7:0] →
  - exactly 480 output lines of 640 strobes each;
  - the columns kept on each line are 0, 3, 6, … 1917, so the gray sequence is 0, 3, 6 … wrapping mod 256.
- Same frame with gray = row[7:0] → the kept source rows are 0, 2, 5, 7, 9, 11, 14, 16 … and the last one is 1078. No strobes appear on rows 1079 or above.
- Ratio 1.0 with SRC = DST = 64×8 → the output equals the input delayed by exactly 1 cycle, bit for bit, including vsync.
- vsync falls after 300 source lines under the default parameters →
  - frame_short pulses once;
  - the FSM returns to S_IDLE;
  - the next full frame produces 480×640 pixels.
- rst pulsed at source line 500 →
  - all outputs are 0 the next cycle;
  - there is no output for the rest of that frame;
  - the following frame is complete and correct.
- Over-long 2000-pixel lines and 1100-line frame → still 640 pixels per line and 480 lines; frame_short stays 0.
